// File: rtl/adc_sdo_emulator.sv
// ADC SDO responder: synchronizes per-group CNV_n/SCK strobes and shifts
// deterministic pattern words out on the SDO lanes, MSB first.
`timescale 1ns/1ps
module adc_sdo_emulator #(
    parameter int unsigned N_SCK       = 4,
    parameter int unsigned N_SDO       = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_const,
    input  logic              i_clr,
    input  logic [N_SCK-1:0]  i_adc_cnv_n,
    input  logic [N_SCK-1:0]  i_adc_sck,
    output logic [N_SDO-1:0]  o_adc_sdo,
    output logic [31:0]       o_conv_count,
    output logic [N_SCK-1:0]  o_overrun
);
    localparam int unsigned LPG   = N_SDO / N_SCK;
    localparam int unsigned REM_W = $clog2(DATA_W);
    localparam int unsigned TAG_W = DATA_W - 4;

    typedef enum logic {S_IDLE, S_SHIFT} state_e;

    logic [N_SCK-1:0]  cnv_sync_q [SYNC_STAGES];
    logic [N_SCK-1:0]  sck_sync_q [SYNC_STAGES];
    logic [N_SCK-1:0]  cnv_prev_q, sck_prev_q;
    logic [N_SCK-1:0]  cnv_fall_c, sck_fall_c;

    state_e            state_q     [N_SCK];
    state_e            state_d     [N_SCK];
    logic [REM_W-1:0]  rem_q       [N_SCK];
    logic [REM_W-1:0]  rem_d       [N_SCK];
    logic [DATA_W-1:0] frame_cnt_q [N_SCK];
    logic [DATA_W-1:0] frame_cnt_d [N_SCK];
    logic [DATA_W-1:0] shreg_q     [N_SDO];
    logic [DATA_W-1:0] shreg_d     [N_SDO];
    logic [DATA_W-1:0] word_c;
    logic [N_SDO-1:0]  sdo_q, sdo_d;
    logic [31:0]       conv_count_q, conv_count_d;
    logic [N_SCK-1:0]  overrun_q, overrun_d;

    // Pattern word for one lane, based on the group's frame count before increment
    function automatic logic [DATA_W-1:0] pattern_word(
        input logic [1:0]        mode,
        input logic [DATA_W-1:0] cst,
        input logic [DATA_W-1:0] cnt,
        input int unsigned       lane
    );
        logic [DATA_W-1:0] w;
        w = '0;
        case (mode)
            2'd0:    w = cnt + DATA_W'(lane);
            2'd1:    w = cst;
            2'd2:    for (int unsigned b = 0; b < DATA_W; b++) w[b] = 1'(b) ^ cnt[0];
            default: w = {4'(lane), cnt[TAG_W-1:0]};
        endcase
        return w;
    endfunction

    // Strobe synchronizers plus one edge-detect register per signal
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                cnv_sync_q[s] <= '1;
                sck_sync_q[s] <= '0;
            end
            cnv_prev_q <= '1;
            sck_prev_q <= '0;
        end else begin
            cnv_sync_q[0] <= i_adc_cnv_n;
            sck_sync_q[0] <= i_adc_sck;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                cnv_sync_q[s] <= cnv_sync_q[s-1];
                sck_sync_q[s] <= sck_sync_q[s-1];
            end
            cnv_prev_q <= cnv_sync_q[SYNC_STAGES-1];
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    assign cnv_fall_c = cnv_prev_q & ~cnv_sync_q[SYNC_STAGES-1];
    assign sck_fall_c = sck_prev_q & ~sck_sync_q[SYNC_STAGES-1];

    // Per-group IDLE/SHIFT next state; a convert edge always beats a shift edge
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        frame_cnt_d  = frame_cnt_q;
        shreg_d      = shreg_q;
        sdo_d        = sdo_q;
        conv_count_d = conv_count_q;
        overrun_d    = overrun_q;
        word_c       = '0;
        if (i_clr) begin
            conv_count_d = '0;
            overrun_d    = '0;
        end
        for (int unsigned g = 0; g < N_SCK; g++) begin
            if (!i_enable) begin
                state_d[g] = S_IDLE;
                rem_d[g]   = '0;
                for (int unsigned k = 0; k < LPG; k++) sdo_d[g*LPG+k] = 1'b0;
            end else if (cnv_fall_c[g]) begin
                if (state_q[g] == S_SHIFT) overrun_d[g] = 1'b1;
                for (int unsigned k = 0; k < LPG; k++) begin
                    word_c = pattern_word(i_mode, i_const, frame_cnt_q[g], g*LPG+k);
                    shreg_d[g*LPG+k] = word_c;
                    sdo_d[g*LPG+k]   = word_c[DATA_W-1];
                end
                rem_d[g]       = REM_W'(DATA_W-1);
                frame_cnt_d[g] = frame_cnt_q[g] + DATA_W'(1);
                state_d[g]     = S_SHIFT;
                if (g == 0 && !i_clr) conv_count_d = conv_count_q + 32'd1;
            end else if (sck_fall_c[g]) begin
                if (state_q[g] == S_SHIFT) begin
                    if (rem_q[g] == '0) begin
                        state_d[g] = S_IDLE;
                        for (int unsigned k = 0; k < LPG; k++) sdo_d[g*LPG+k] = 1'b0;
                    end else begin
                        rem_d[g] = rem_q[g] - REM_W'(1);
                        for (int unsigned k = 0; k < LPG; k++) begin
                            shreg_d[g*LPG+k] = shreg_q[g*LPG+k] << 1;
                            sdo_d[g*LPG+k]   = shreg_q[g*LPG+k][DATA_W-2];
                        end
                    end
                end else begin
                    overrun_d[g] = 1'b1;
                    for (int unsigned k = 0; k < LPG; k++) sdo_d[g*LPG+k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned g = 0; g < N_SCK; g++) begin
                state_q[g]     <= S_IDLE;
                rem_q[g]       <= '0;
                frame_cnt_q[g] <= '0;
            end
            for (int unsigned v = 0; v < N_SDO; v++) shreg_q[v] <= '0;
            sdo_q        <= '0;
            conv_count_q <= '0;
            overrun_q    <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            frame_cnt_q  <= frame_cnt_d;
            shreg_q      <= shreg_d;
            sdo_q        <= sdo_d;
            conv_count_q <= conv_count_d;
            overrun_q    <= overrun_d;
        end
    end

    assign o_adc_sdo    = sdo_q;
    assign o_conv_count = conv_count_q;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_adc_sdo_emulator.sv
// Bench for adc_sdo_emulator: directed strobe sequences, a frame-level
// reference model compared every cycle, and literal checks on captured words.
`timescale 1ns/1ps
module tb_adc_sdo_emulator;
    localparam int N_SCK       = 4;
    localparam int N_SDO       = 8;
    localparam int DATA_W      = 16;
    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 1;
    localparam int LPG         = N_SDO / N_SCK;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        clr;
    logic [1:0]  mode;
    logic [15:0] cst;
    logic [3:0]  cnv_n;
    logic [3:0]  sck;
    logic [7:0]  sdo;
    logic [31:0] conv_count;
    logic [3:0]  overrun;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] cap [N_SDO];
    int          lat;

    always #5 clk = ~clk;

    adc_sdo_emulator #(
        .N_SCK(N_SCK), .N_SDO(N_SDO), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_mode(mode), .i_const(cst),
        .i_clr(clr), .i_adc_cnv_n(cnv_n), .i_adc_sck(sck), .o_adc_sdo(sdo),
        .o_conv_count(conv_count), .o_overrun(overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: pin history delayed by the pin-to-SDO latency, frame-level state
    logic [3:0] h_cnv [LAT+1];
    logic [3:0] h_sck [LAT+1];
    bit         m_active [N_SCK];
    int         m_bit    [N_SCK];
    int         m_fcnt   [N_SCK];
    int         m_word   [N_SDO];
    int         m_count;
    logic [3:0] m_ovr;

    function automatic int model_word(input int md, input int c, input int cnt, input int v);
        case (md)
            0:       return (cnt + v) % 65536;
            1:       return c;
            2:       return (cnt % 2 == 0) ? 'hAAAA : 'h5555;
            default: return v * 4096 + cnt % 4096;
        endcase
    endfunction

    function automatic logic [7:0] model_sdo();
        logic [7:0] r;
        int g;
        r = '0;
        for (int v = 0; v < N_SDO; v++) begin
            g = v / LPG;
            if (m_active[g]) r[v] = 1'((m_word[v] >> (DATA_W - 1 - m_bit[g])) & 1);
        end
        return r;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i <= LAT; i++) begin
                h_cnv[i] = '1;
                h_sck[i] = '0;
            end
            for (int g = 0; g < N_SCK; g++) begin
                m_active[g] = 0;
                m_bit[g]    = 0;
                m_fcnt[g]   = 0;
            end
            for (int v = 0; v < N_SDO; v++) m_word[v] = 0;
            m_count = 0;
            m_ovr   = '0;
        end else begin
            for (int i = LAT; i > 0; i--) begin
                h_cnv[i] = h_cnv[i-1];
                h_sck[i] = h_sck[i-1];
            end
            h_cnv[0] = cnv_n;
            h_sck[0] = sck;
            if (clr) begin
                m_count = 0;
                m_ovr   = '0;
            end
            for (int g = 0; g < N_SCK; g++) begin
                bit cf, sf;
                cf = h_cnv[LAT][g] && !h_cnv[LAT-1][g];
                sf = h_sck[LAT][g] && !h_sck[LAT-1][g];
                if (!enable) begin
                    m_active[g] = 0;
                end else if (cf) begin
                    if (m_active[g]) m_ovr[g] = 1'b1;
                    for (int k = 0; k < LPG; k++)
                        m_word[g*LPG+k] = model_word(int'(mode), int'(cst), m_fcnt[g], g*LPG+k);
                    m_fcnt[g]   = (m_fcnt[g] + 1) % 65536;
                    m_bit[g]    = 0;
                    m_active[g] = 1;
                    if (g == 0 && !clr) m_count++;
                end else if (sf) begin
                    if (m_active[g]) begin
                        m_bit[g]++;
                        if (m_bit[g] == DATA_W) m_active[g] = 0;
                    end else begin
                        m_ovr[g] = 1'b1;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("sdo", 32'(sdo), 32'(model_sdo()));
        check("conv_count", conv_count, 32'(m_count));
        check("overrun", 32'(overrun), 32'(m_ovr));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic start(input logic [3:0] m);
        cnv_n = cnv_n & ~m;
        tick(2);
        cnv_n = cnv_n | m;
        tick(3);
    endtask

    // Receiver view: sample every lane just before each SCK rising edge
    task automatic shift_bits(input logic [3:0] m, input int n);
        for (int v = 0; v < N_SDO; v++) cap[v] = '0;
        for (int i = 0; i < n; i++) begin
            for (int v = 0; v < N_SDO; v++) cap[v] = {cap[v][30:0], sdo[v]};
            sck = sck | m;
            tick(5);
            sck = sck & ~m;
            tick(5);
        end
    endtask

    task automatic frame(input logic [3:0] m);
        start(m);
        shift_bits(m, 16);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_sdo", 32'(sdo), 32'h0);
        check("rst_count", conv_count, 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        cnv_n = '1;
        sck   = '0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        rst_n  = 1'b1;
        enable = 1'b0;
        clr    = 1'b0;
        mode   = 2'd0;
        cst    = '0;
        cnv_n  = '1;
        sck    = '0;
        #1;
        do_reset();

        // Ramp pattern
        enable = 1'b1;
        mode   = 2'd0;
        frame(4'hF);
        check("ramp_lane0", cap[0], 32'h0000);
        check("ramp_lane5", cap[5], 32'h0005);
        check("sdo_after_16", 32'(sdo), 32'h0);
        frame(4'hF);
        check("ramp_lane0_f2", cap[0], 32'h0001);
        check("count_2", conv_count, 32'd2);
        check("no_overrun", 32'(overrun), 32'h0);

        // Constant and alternating patterns
        mode = 2'd1;
        cst  = 16'hBEEF;
        frame(4'hF);
        for (int v = 0; v < N_SDO; v++) check("const_lane", cap[v], 32'hBEEF);
        do_reset();
        mode = 2'd2;
        frame(4'hF);
        check("alt_even_l0", cap[0], 32'hAAAA);
        check("alt_even_l7", cap[7], 32'hAAAA);
        frame(4'hF);
        check("alt_odd_l0", cap[0], 32'h5555);

        // Lane-tagged count
        do_reset();
        mode = 2'd3;
        repeat (3) frame(4'hF);
        check("tag_lane7", cap[7], 32'h7002);
        check("tag_lane0", cap[0], 32'h0002);

        // Aborted frame on group 1, extra SCK on group 2, simultaneous edges on group 3
        start(4'h2);
        shift_bits(4'h2, 5);
        frame(4'h2);
        check("abort_lane2", cap[2], 32'h2004);
        check("abort_lane3", cap[3], 32'h3004);
        check("abort_ovr", 32'(overrun), 32'h2);
        start(4'h4);
        shift_bits(4'h4, 17);
        check("sck17_lane4", cap[4], 32'h8006);
        check("sck17_ovr", 32'(overrun), 32'h6);
        check("sck17_sdo", 32'(sdo), 32'h0);
        sck = sck | 4'h8;
        tick(5);
        cnv_n = cnv_n & ~4'h8;
        sck   = sck & ~4'h8;
        tick(2);
        cnv_n = cnv_n | 4'h8;
        tick(3);
        shift_bits(4'h8, 16);
        check("simul_lane6", cap[6], 32'h6003);
        check("simul_ovr", 32'(overrun), 32'h6);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_ovr", 32'(overrun), 32'h0);
        check("clr_count", conv_count, 32'h0);

        // Disable mid-frame, no replay of an edge seen while disabled
        mode = 2'd1;
        cst  = 16'hFFFF;
        start(4'h1);
        shift_bits(4'h1, 8);
        check("en_pre", 32'(sdo[1:0]), 32'h3);
        enable = 1'b0;
        tick(1);
        check("en_off", 32'(sdo), 32'h0);
        shift_bits(4'h1, 8);
        cnv_n[0] = 1'b0;
        tick(5);
        enable = 1'b1;
        tick(5);
        check("no_replay", 32'(sdo), 32'h0);
        cnv_n[0] = 1'b1;
        tick(3);
        cst = 16'h1234;
        frame(4'h1);
        check("reen_lane0", cap[0], 32'h1234);
        check("reen_lane1", cap[1], 32'h1234);
        check("reen_ovr", 32'(overrun), 32'h0);

        // Reset mid-frame, then pin-to-SDO latency
        cst = 16'hBEEF;
        start(4'hF);
        shift_bits(4'hF, 3);
        check("mid_sdo", 32'(sdo), 32'hFF);
        do_reset();
        cnv_n = '0;
        lat   = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (sdo != 8'h00 && lat == 0) lat = n;
        end
        #2;
        check("latency", 32'(lat), 32'd3);
        cnv_n = '1;
        tick(3);
        shift_bits(4'hF, 16);
        check("post_rst_lane0", cap[0], 32'hBEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
